alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
Upstream operand-entry stage for the board-level ALU test harness. It synchronises and debounces the raw push buttons and slide switches, then steps through a state machine that loads operand A, operand B and the ALU opcode. The loaded values drive the ALU inputs. One cycle later it captures the ALU result and flags into hold registers for the display stage.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced key changes level (10 ms at 50 MHz)
SYNC_STAGES, 2, flip-flop synchroniser depth on every raw key and switch input

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  synchronous active-low reset
key_n  input  4  raw push buttons, active-low; key_n[0]=ENTER, key_n[3]=CLEAR, key_n[2:1] unused
sw  input  17  raw switches; sw[15:0] operand data, sw[16] sign bit; sw[3:0] also supplies the opcode
portA  output  32  ALU operand A
portB  output  32  ALU operand B
aluop  output  4  ALU opcode (aluop_t)
alu_result  input  32  ALU result, combinational from portA/portB/aluop
alu_zero, alu_neg, alu_ovf  input  1 each  ALU flags
result_q  output  32  captured ALU result
flags_q  output  3  captured flags {ovf,neg,zero}
state_o  output  3  current FSM state encoding
done  output  1  one-cycle pulse when result_q/flags_q are updated

Behaviour:
- Clock and reset: one clock, CLK. nRST is synchronous and active-low, sampled on the CLK rising edge.
- Reset values: portA, portB, aluop, result_q, flags_q, done all 0. state_o=GET_A (0). Synchroniser flops =1 (key released). Debounced levels =1. Debounce counters =0.
- Synchroniser: key_n and sw each pass through SYNC_STAGES flops. There is no other path from raw inputs into logic.
- Debounce, per key:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - Any glitch before terminal count restarts the count.
- Press event: one-cycle registered pulse on a debounced 1->0 transition. A held key produces exactly one event. Release produces no event.
- Operand word: {{16{sw_s[16]}}, sw_s[15:0]}, where sw_s is the synchronised switch value.
- FSM encoding: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4. Values 5-7 are illegal and return to GET_A on the next edge.
- GET_A: on ENTER event, portA <= operand word; go to GET_B.
- GET_B: on ENTER event, portB <= operand word; go to GET_OP.
- GET_OP: on ENTER event, aluop <= sw_s[3:0]; go to EXEC. Unused opcode values pass through unmodified.
- EXEC: lasts exactly one cycle, giving the ALU a full cycle on the new inputs.
  - At the end of EXEC: result_q <= alu_result, flags_q <= {alu_ovf,alu_neg,alu_zero}, done <= 1; go to SHOW.
  - done is high for exactly the first SHOW cycle.
  - ENTER arriving in EXEC is dropped.
- SHOW: holds all registers. On ENTER event, go to GET_A. portA, portB, aluop and result_q retain their values until overwritten.
- CLEAR event, from any state: go to GET_A. portA, portB, aluop, result_q, flags_q <= 0. done <= 0.
  - CLEAR wins over a simultaneous ENTER.
  - CLEAR during EXEC suppresses the capture and the done pulse.
- Latency from key to event:
  - A raw key held low continuously from cycle t produces its event in cycle t+SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - The FSM transition takes effect on the edge ending the event cycle.
- Reset mid-operation: everything returns to reset values. A key still held low when nRST deasserts yields one press event after the debounce interval.
- result_q and flags_q change only at the end of EXEC or on CLEAR/reset.

Test Plan:
1. Reset, with DEBOUNCE_CYCLES=4 for all tests: hold nRST=0 for 3 cycles -> all outputs 0, state_o=0, done=0; no events while keys are released.
2. Full ADD sequence: sw=0x00005, ENTER; sw=0x00003, ENTER; sw[3:0]=ALU_ADD, ENTER -> portA=5, portB=3, state passes through 3 for one cycle, then result_q=0x00000008, flags_q=3'b000, done high exactly 1 cycle, state_o=4.
3. Sign extension and flags: sw=0x1FFFF -> portA=0xFFFFFFFF; B=0x00001; op ALU_SUB -> result_q=0xFFFFFFFE, flags_q=3'b010.
4. Bounce: key_n[0] toggles every 2 cycles for 20 cycles, then stays low for 100 cycles -> exactly one ENTER event, at SYNC_STAGES+4+1 cycles after the final stable low; state advances by one only.
5. CLEAR priority: in GET_B assert ENTER and CLEAR together; separately, assert CLEAR landing in EXEC -> state_o=0, all registers 0, no done pulse in either case.
6. Reset in GET_OP with key_n[0] held low through reset -> outputs 0 immediately after the reset edge; after release, one ENTER event loads portA; no second event while the key is held.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// Operand-entry sequencer for the board ALU harness: synchronises and
// debounces keys/switches, loads A, B and opcode, then captures the result.
package alu_seq_pkg;
    typedef logic [3:0] aluop_t;
    localparam aluop_t ALU_SLL  = 4'd0;
    localparam aluop_t ALU_SRL  = 4'd1;
    localparam aluop_t ALU_ADD  = 4'd2;
    localparam aluop_t ALU_SUB  = 4'd3;
    localparam aluop_t ALU_AND  = 4'd4;
    localparam aluop_t ALU_OR   = 4'd5;
    localparam aluop_t ALU_XOR  = 4'd6;
    localparam aluop_t ALU_NOR  = 4'd7;
    localparam aluop_t ALU_SLT  = 4'd8;
    localparam aluop_t ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;
endpackage

module alu_input_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  key_n,
    input  logic [16:0] sw,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output aluop_t      aluop,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    output logic [31:0] result_q,
    output logic [2:0]  flags_q,
    output logic [2:0]  state_o,
    output logic        done
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][3:0]  ksync_q, ksync_d;
    logic [SYNC_STAGES-1:0][16:0] ssync_q, ssync_d;
    logic [3:0]                   key_s;
    logic [16:0]                  sw_s;

    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         db_q, db_d;
    logic [3:0]         evt_q, evt_d;
    logic               ent_evt, clr_evt;
    logic               unused_evt;

    state_t      state_q, state_d;
    logic [31:0] porta_q, porta_d;
    logic [31:0] portb_q, portb_d;
    aluop_t      aluop_q, aluop_d;
    logic [31:0] result_d;
    logic [2:0]  flags_d;
    logic        done_q, done_d;
    logic [31:0] operand;

    always_comb begin
        ksync_d[0] = key_n;
        ssync_d[0] = sw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ksync_d[i] = ksync_q[i-1];
            ssync_d[i] = ssync_q[i-1];
        end
    end

    assign key_s   = ksync_q[SYNC_STAGES-1];
    assign sw_s    = ssync_q[SYNC_STAGES-1];
    assign operand = {{16{sw_s[16]}}, sw_s[15:0]};

    // Level only flips after a full run of disagreeing samples.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            db_d[k]  = db_q[k];
            cnt_d[k] = '0;
            if (key_s[k] != db_q[k]) begin
                if (cnt_q[k] == CW'(DEBOUNCE_CYCLES)) begin
                    db_d[k] = key_s[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        evt_d = db_q & ~db_d;
    end

    assign ent_evt    = evt_q[0];
    assign clr_evt    = evt_q[3];
    assign unused_evt = ^evt_q[2:1];

    always_comb begin
        state_d  = state_q;
        porta_d  = porta_q;
        portb_d  = portb_q;
        aluop_d  = aluop_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        if (clr_evt) begin
            state_d  = GET_A;
            porta_d  = '0;
            portb_d  = '0;
            aluop_d  = '0;
            result_d = '0;
            flags_d  = '0;
        end else begin
            unique case (state_q)
                GET_A: if (ent_evt) begin
                    porta_d = operand;
                    state_d = GET_B;
                end
                GET_B: if (ent_evt) begin
                    portb_d = operand;
                    state_d = GET_OP;
                end
                GET_OP: if (ent_evt) begin
                    aluop_d = sw_s[3:0];
                    state_d = EXEC;
                end
                EXEC: begin
                    result_d = alu_result;
                    flags_d  = {alu_ovf, alu_neg, alu_zero};
                    done_d   = 1'b1;
                    state_d  = SHOW;
                end
                SHOW: if (ent_evt) begin
                    state_d = GET_A;
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ksync_q  <= '1;
            ssync_q  <= '1;
            cnt_q    <= '0;
            db_q     <= '1;
            evt_q    <= '0;
            state_q  <= GET_A;
            porta_q  <= '0;
            portb_q  <= '0;
            aluop_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            ksync_q  <= ksync_d;
            ssync_q  <= ssync_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            evt_q    <= evt_d;
            state_q  <= state_d;
            porta_q  <= porta_d;
            portb_q  <= portb_d;
            aluop_q  <= aluop_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign portA   = porta_q;
    assign portB   = portb_q;
    assign aluop   = aluop_q;
    assign state_o = state_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Random and directed stimulus for alu_input_sequencer, checked every
// cycle against a behavioural model of keys, operand entry and capture.
module tb_alu_input_sequencer;
    import alu_seq_pkg::*;

    localparam int DB = 4;
    localparam int SS = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  key_n;
    logic [16:0] sw;
    logic [31:0] portA, portB, alu_result, result_q;
    aluop_t      aluop;
    logic        alu_zero, alu_neg, alu_ovf;
    logic [2:0]  flags_q, state_o;
    logic        done;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
        .portA(portA), .portB(portB), .aluop(aluop),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf),
        .result_q(result_q), .flags_q(flags_q),
        .state_o(state_o), .done(done)
    );

    always #5 CLK = ~CLK;

    // {ovf, neg, zero, result}
    function automatic logic [34:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {v, r[31], (r == 32'd0), r};
    endfunction

    always_comb {alu_ovf, alu_neg, alu_zero, alu_result} = alu_f(portA, portB, aluop);

    int nvec = 0;
    int nerr = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [3:0]  mk [SS];
    logic [16:0] ms [SS];
    logic [3:0]  mdb, mevt;
    logic [3:0]  shist [$];
    int          flip_at [4];
    int          mst;
    logic [31:0] ma, mb, mres;
    logic [3:0]  mop;
    logic [2:0]  mflg;
    logic        mdone;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) begin
            mk[i] = '1;
            ms[i] = '1;
        end
        mdb = 4'hF;
        mevt = 4'h0;
        shist.delete();
        for (int k = 0; k < 4; k++) flip_at[k] = 0;
        mst = 0;
        ma = 0; mb = 0; mres = 0; mop = 0; mflg = 0; mdone = 0;
    endtask

    task automatic model_step(input logic [3:0] k, input logic [16:0] s, input logic r);
        logic [31:0] word;
        logic [34:0] alu;
        logic [3:0]  ndb;
        logic        flip;
        int          n;
        if (!r) begin
            model_reset();
            return;
        end
        word = {{16{ms[SS-1][16]}}, ms[SS-1][15:0]};
        mdone = 1'b0;
        if (mevt[3]) begin
            mst = 0; ma = 0; mb = 0; mop = 0; mres = 0; mflg = 0;
        end else begin
            case (mst)
                0: if (mevt[0]) begin ma = word; mst = 1; end
                1: if (mevt[0]) begin mb = word; mst = 2; end
                2: if (mevt[0]) begin mop = ms[SS-1][3:0]; mst = 3; end
                3: begin
                    alu = alu_f(ma, mb, mop);
                    mres = alu[31:0];
                    mflg = alu[34:32];
                    mdone = 1'b1;
                    mst = 4;
                end
                default: if (mevt[0]) mst = 0;
            endcase
        end
        // A key flips once DB+1 consecutive synced samples disagree with it.
        shist.push_back(mk[SS-1]);
        ndb = mdb;
        for (int b = 0; b < 4; b++) begin
            n = shist.size() - flip_at[b];
            if (n >= DB + 1) begin
                flip = 1'b1;
                for (int j = shist.size() - DB - 1; j < shist.size(); j++)
                    if (shist[j][b] == mdb[b]) flip = 1'b0;
                if (flip) begin
                    ndb[b] = ~mdb[b];
                    flip_at[b] = shist.size();
                end
            end
        end
        mevt = mdb & ~ndb;
        mdb = ndb;
        for (int i = SS - 1; i > 0; i--) begin
            mk[i] = mk[i-1];
            ms[i] = ms[i-1];
        end
        mk[0] = k;
        ms[0] = s;
    endtask

    task automatic step(input logic [3:0] k, input logic [16:0] s, input logic r);
        @(negedge CLK);
        chk("portA", portA, ma);
        chk("portB", portB, mb);
        chk("aluop", {28'd0, aluop}, {28'd0, mop});
        chk("result", result_q, mres);
        chk("flags", {29'd0, flags_q}, {29'd0, mflg});
        chk("state", {29'd0, state_o}, mst);
        chk("done", {31'd0, done}, {31'd0, mdone});
        if (done === 1'b1) done_seen++;
        key_n = k;
        sw = s;
        nRST = r;
        model_step(k, s, r);
    endtask

    task automatic press(input logic [3:0] k, input logic [16:0] s);
        repeat (10) step(k, s, 1'b1);
        repeat (10) step(4'hF, s, 1'b1);
    endtask

    initial begin
        int first_j;
        int len;
        int sel;
        logic [3:0]  kv;
        logic [16:0] sv;
        logic        rv;

        key_n = 4'hF;
        sw = '0;
        nRST = 1'b0;
        model_reset();

        repeat (3) step(4'hF, 17'h0, 1'b0);
        chk("t1_state", {29'd0, state_o}, 32'd0);
        chk("t1_portA", portA, 32'd0);
        repeat (12) step(4'hF, 17'h0, 1'b1);
        chk("t1_idle_state", {29'd0, state_o}, 32'd0);
        chk("t1_idle_done", done_seen, 32'd0);

        done_seen = 0;
        press(4'hE, 17'h00005);
        press(4'hE, 17'h00003);
        press(4'hE, {13'd0, ALU_ADD});
        chk("t2_portA", portA, 32'd5);
        chk("t2_portB", portB, 32'd3);
        chk("t2_result", result_q, 32'h8);
        chk("t2_flags", {29'd0, flags_q}, 32'd0);
        chk("t2_state", {29'd0, state_o}, 32'd4);
        chk("t2_done_cnt", done_seen, 32'd1);

        press(4'hE, 17'h0);
        press(4'hE, 17'h1FFFF);
        chk("t3_sext", portA, 32'hFFFF_FFFF);
        press(4'hE, 17'h00001);
        press(4'hE, {13'd0, ALU_SUB});
        chk("t3_result", result_q, 32'hFFFF_FFFE);
        chk("t3_flags", {29'd0, flags_q}, 32'b010);

        press(4'hE, 17'h0);
        for (int i = 0; i < 20; i++)
            step(((i / 2) % 2 == 0) ? 4'hE : 4'hF, 17'h7, 1'b1);
        chk("t4_bounce_state", {29'd0, state_o}, 32'd0);
        first_j = -1;
        for (int j = 0; j < 100; j++) begin
            step(4'hE, 17'h7, 1'b1);
            if (first_j < 0 && state_o == 3'd1) first_j = j;
        end
        chk("t4_lat", first_j, SS + DB + 2);
        repeat (10) step(4'hF, 17'h7, 1'b1);
        chk("t4_state", {29'd0, state_o}, 32'd1);
        chk("t4_portA", portA, 32'd7);

        done_seen = 0;
        press(4'h6, 17'h5);
        chk("t5a_state", {29'd0, state_o}, 32'd0);
        chk("t5a_portA", portA, 32'd0);
        press(4'hE, 17'h1);
        press(4'hE, 17'h2);
        step(4'hE, {13'd0, ALU_ADD}, 1'b1);
        repeat (12) step(4'h6, {13'd0, ALU_ADD}, 1'b1);
        repeat (10) step(4'hF, {13'd0, ALU_ADD}, 1'b1);
        chk("t5b_state", {29'd0, state_o}, 32'd0);
        chk("t5b_result", result_q, 32'd0);
        chk("t5b_aluop", {28'd0, aluop}, 32'd0);
        chk("t5_done_cnt", done_seen, 32'd0);

        press(4'hE, 17'h11);
        press(4'hE, 17'h22);
        repeat (3) step(4'hE, 17'h9, 1'b1);
        repeat (2) step(4'hE, 17'h9, 1'b0);
        chk("t6_rst_state", {29'd0, state_o}, 32'd0);
        chk("t6_rst_portB", portB, 32'd0);
        step(4'hE, 17'h9, 1'b0);
        repeat (30) step(4'hE, 17'h9, 1'b1);
        chk("t6_portA", portA, 32'd9);
        chk("t6_state", {29'd0, state_o}, 32'd1);
        repeat (10) step(4'hF, 17'h9, 1'b1);

        for (int seg = 0; seg < 400; seg++) begin
            rv = ($urandom_range(0, 49) != 0);
            len = rv ? $urandom_range(1, 12) : $urandom_range(1, 3);
            sel = $urandom_range(0, 9);
            if (sel <= 3) kv = 4'hF;
            else if (sel <= 6) kv = 4'hE;
            else if (sel == 7) kv = 4'h7;
            else if (sel == 8) kv = 4'h6;
            else kv = 4'($urandom());
            sv = 17'($urandom());
            repeat (len) step(kv, sv, rv);
        end
        repeat (12) step(4'hF, 17'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
